// File: rtl/controlador_pkg.sv
// Shared definitions for the HD<->RAM program transfer engine.
//   estado_t        : transfer FSM states
//   MODO_LOAD/STORE : transfer direction encodings (HD->RAM / RAM->HD)
//   hd_start_width  : width that holds indice*PROG_SIZE + HD_BASE without truncation
package controlador_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } estado_t;

  localparam logic MODO_LOAD  = 1'b0;
  localparam logic MODO_STORE = 1'b1;

  function automatic int unsigned hd_start_width(input int unsigned addr_width,
                                                 input int unsigned prog_size);
    return addr_width + $clog2(prog_size) + 1;
  endfunction

endpackage

// File: rtl/controlador_if.sv
// Control and data bus of the transfer engine.
//   master : CPU control unit plus HD/RAM read ports (drive request and read data)
//   slave  : transfer engine (drives addresses, write data, strobes and status)
interface controlador_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  Start;
  logic                  Modo;
  logic                  Abort;
  logic [ADDR_WIDTH-1:0] indice_programa;
  logic [DATA_WIDTH-1:0] dado_HD_in;
  logic [DATA_WIDTH-1:0] dado_RAM_in;
  logic [ADDR_WIDTH-1:0] endereco_HD;
  logic [ADDR_WIDTH-1:0] endereco_RAM;
  logic [DATA_WIDTH-1:0] dado_out;
  logic                  escreve_HD;
  logic                  escreve_RAM;
  logic                  carregando;
  logic                  concluido;
  logic                  erro;

  modport master (
    output Start, Modo, Abort, indice_programa, dado_HD_in, dado_RAM_in,
    input  endereco_HD, endereco_RAM, dado_out, escreve_HD, escreve_RAM,
           carregando, concluido, erro
  );

  modport slave (
    input  Start, Modo, Abort, indice_programa, dado_HD_in, dado_RAM_in,
    output endereco_HD, endereco_RAM, dado_out, escreve_HD, escreve_RAM,
           carregando, concluido, erro
  );
endinterface

// File: rtl/controlador_transferencia_contador.sv
// HD/RAM pointers and word counter for one program transfer.
//   clk, rst  : clock, async active-high reset
//   load      : load hd_ptr with hd_start, ram_ptr with RAM_BASE, clear the counter
//   inc       : one word written; advance counter and pointers
//   hd_ptr    : current HD address
//   ram_ptr   : current RAM address
//   ultimo    : the word being transferred is the last one of the image
module contador_enderecos #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned PROG_SIZE  = 150,
  parameter int unsigned RAM_BASE   = 550
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] hd_start,
  output logic [ADDR_WIDTH-1:0] hd_ptr,
  output logic [ADDR_WIDTH-1:0] ram_ptr,
  output logic                  ultimo
);

  localparam int unsigned CW = $clog2(PROG_SIZE + 1);

  logic [CW-1:0] cnt;

  assign ultimo = (cnt == CW'(PROG_SIZE - 1));

  // Pointers stay on the last word so the addresses hold their final value
  // when idle and can never wrap past the top of the address space.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hd_ptr  <= '0;
      ram_ptr <= '0;
      cnt     <= '0;
    end else if (load) begin
      hd_ptr  <= hd_start;
      ram_ptr <= ADDR_WIDTH'(RAM_BASE);
      cnt     <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
      if (!ultimo) begin
        hd_ptr  <= hd_ptr + 1'b1;
        ram_ptr <= ram_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/controlador_transferencia.sv
// HD<->RAM program transfer engine: copies one PROG_SIZE-word image between
// the HD and the RAM program window, one word every RD_LAT+2 cycles.
//   Clock, Reset : clock, async active-high reset
//   bus (slave)  : Start/Modo/Abort/indice_programa request, HD/RAM read data,
//                  addresses, write data, write strobes, carregando/concluido/erro
module controlador_transferencia
  import controlador_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PROG_SIZE  = 150,
  parameter int unsigned HD_BASE    = 200,
  parameter int unsigned RAM_BASE   = 550,
  parameter int unsigned RAM_SIZE   = 700,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic         Clock,
  input  logic         Reset,
  controlador_if.slave bus
);

  localparam int unsigned HW  = hd_start_width(ADDR_WIDTH, PROG_SIZE);
  localparam int unsigned HW1 = HW + 1;
  localparam int unsigned LW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  if (RAM_BASE + PROG_SIZE > RAM_SIZE) begin : g_ram_window_check
    $error("RAM program window does not fit in RAM_SIZE");
  end
  if (RD_LAT < 1) begin : g_rd_lat_check
    $error("RD_LAT must be at least 1");
  end

  estado_t               state, next_state;
  logic                  modo;
  logic [LW-1:0]         lat_cnt;
  logic                  lat_done;
  logic [DATA_WIDTH-1:0] dado_q;
  logic                  carregando_q, concluido_q, erro_q;
  logic [HW-1:0]         hd_start;
  logic                  range_ok;
  logic                  load, inc, capture, erro_c;
  logic [ADDR_WIDTH-1:0] hd_ptr, ram_ptr;
  logic                  ultimo;

  // First HD address of the requested image, at full width for the range check.
  assign hd_start = HW'(bus.indice_programa) * HW'(PROG_SIZE) + HW'(HD_BASE);
  assign range_ok = (HW1'(hd_start) + HW1'(PROG_SIZE)) <= (HW1'(1) << ADDR_WIDTH);
  assign lat_done = (lat_cnt == LW'(RD_LAT - 1));

  contador_enderecos #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PROG_SIZE  (PROG_SIZE),
    .RAM_BASE   (RAM_BASE)
  ) u_contador (
    .clk      (Clock),
    .rst      (Reset),
    .load     (load),
    .inc      (inc),
    .hd_start (ADDR_WIDTH'(hd_start)),
    .hd_ptr   (hd_ptr),
    .ram_ptr  (ram_ptr),
    .ultimo   (ultimo)
  );

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next state and datapath controls.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    inc        = 1'b0;
    capture    = 1'b0;
    erro_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.Start && !bus.Abort) begin
          if (range_ok) begin
            load       = 1'b1;
            next_state = ST_ISSUE;
          end else begin
            erro_c = 1'b1;
          end
        end
      end
      ST_ISSUE: next_state = bus.Abort ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (bus.Abort) begin
          next_state = ST_IDLE;
        end else if (lat_done) begin
          capture    = 1'b1;
          next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.Abort) begin
          next_state = ST_IDLE;
        end else begin
          inc        = 1'b1;
          next_state = ultimo ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Direction latch, read-latency counter, data register and status outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      modo         <= MODO_LOAD;
      lat_cnt      <= '0;
      dado_q       <= '0;
      carregando_q <= 1'b0;
      concluido_q  <= 1'b0;
      erro_q       <= 1'b0;
    end else begin
      if (load) modo <= bus.Modo;
      if (state == ST_WAIT && !lat_done) lat_cnt <= lat_cnt + 1'b1;
      else                               lat_cnt <= '0;
      if (capture) dado_q <= (modo == MODO_LOAD) ? bus.dado_HD_in : bus.dado_RAM_in;
      carregando_q <= (next_state == ST_ISSUE) || (next_state == ST_WAIT) ||
                      (next_state == ST_WRITE);
      concluido_q  <= (next_state == ST_DONE);
      erro_q       <= erro_c;
    end
  end

  assign bus.endereco_HD  = hd_ptr;
  assign bus.endereco_RAM = ram_ptr;
  assign bus.dado_out     = dado_q;
  assign bus.carregando   = carregando_q;
  assign bus.concluido    = concluido_q;
  assign bus.erro         = erro_q;

  // Strobes are gated by Abort so that an abort landing in WRITE writes nothing.
  assign bus.escreve_RAM = (state == ST_WRITE) && (modo == MODO_LOAD)  && !bus.Abort;
  assign bus.escreve_HD  = (state == ST_WRITE) && (modo == MODO_STORE) && !bus.Abort;

endmodule

// File: tb/tb_controlador_transferencia.sv
// Self-checking bench: two engines (RD_LAT=1 and RD_LAT=3) with HD/RAM read
// models; every expected write is queued when Start is driven and matched
// (direction, address, data, cycle) when the strobe appears.
module tb_controlador_transferencia;
  import controlador_pkg::*;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned PS  = 150;
  localparam int unsigned HDB = 200;
  localparam int unsigned RB  = 550;
  localparam int unsigned RS  = 700;

  typedef struct {
    bit          to_hd;
    logic [11:0] addr;
    logic [31:0] data;
    longint      cyc;
  } wr_t;

  typedef struct {
    bit lat3;
    bit modo;
    int idx;
    bit exp_err;
    int exp_done;
    int exp_last;
  } tcase_t;

  logic   clk = 1'b0;
  logic   rst1, rst3;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;
  wr_t    q1[$];
  wr_t    q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  controlador_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
  controlador_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if3 ();

  controlador_transferencia #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROG_SIZE(PS), .HD_BASE(HDB),
    .RAM_BASE(RB), .RAM_SIZE(RS), .RD_LAT(1)
  ) dut1 (.Clock(clk), .Reset(rst1), .bus(if1));

  controlador_transferencia #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROG_SIZE(PS), .HD_BASE(HDB),
    .RAM_BASE(RB), .RAM_SIZE(RS), .RD_LAT(3)
  ) dut3 (.Clock(clk), .Reset(rst3), .bus(if3));

  function automatic logic [31:0] hd_word(input logic [11:0] a);
    return {8'hAD, a, ~a};
  endfunction

  function automatic logic [31:0] ram_word(input logic [11:0] a);
    return {8'h5A, ~a, a};
  endfunction

  // Read ports with RD_LAT cycles of address-to-data latency.
  logic [11:0] hd_a1, ram_a1;
  logic [11:0] hd_p3[3];
  logic [11:0] ram_p3[3];
  always @(posedge clk) begin
    hd_a1     <= if1.endereco_HD;
    ram_a1    <= if1.endereco_RAM;
    hd_p3[0]  <= if3.endereco_HD;
    ram_p3[0] <= if3.endereco_RAM;
    for (int i = 1; i < 3; i++) begin
      hd_p3[i]  <= hd_p3[i-1];
      ram_p3[i] <= ram_p3[i-1];
    end
  end
  assign if1.dado_HD_in  = hd_word(hd_a1);
  assign if1.dado_RAM_in = ram_word(ram_a1);
  assign if3.dado_HD_in  = hd_word(hd_p3[2]);
  assign if3.dado_RAM_in = ram_word(ram_p3[2]);

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle count %0d)", name, act, exp, cyc);
    end
  endtask

  // Match an observed write strobe against the head of the scoreboard.
  task automatic check_write(input bit l3, input logic whd, input logic wram,
                             input logic [11:0] ahd, input logic [11:0] aram,
                             input logic [31:0] d);
    wr_t e;
    int  sz;
    if (!(whd || wram)) return;
    checks++;
    sz = l3 ? q3.size() : q1.size();
    if (whd && wram) begin
      errors++;
      $display("FAIL both_strobes lat%0d: escreve_HD and escreve_RAM high together", l3 ? 3 : 1);
    end else if (sz == 0) begin
      errors++;
      $display("FAIL unexpected_write lat%0d: hd=%0b addr=%0d data=%h, expected no write",
               l3 ? 3 : 1, whd, whd ? ahd : aram, d);
    end else begin
      e = l3 ? q3.pop_front() : q1.pop_front();
      if (e.to_hd != whd || e.addr != (whd ? ahd : aram) || e.data != d || e.cyc != cyc) begin
        errors++;
        $display("FAIL write lat%0d: got hd=%0b addr=%0d data=%h cyc=%0d, expected hd=%0b addr=%0d data=%h cyc=%0d",
                 l3 ? 3 : 1, whd, whd ? ahd : aram, d, cyc, e.to_hd, e.addr, e.data, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    check_write(1'b0, if1.escreve_HD, if1.escreve_RAM, if1.endereco_HD, if1.endereco_RAM, if1.dado_out);
    check_write(1'b1, if3.escreve_HD, if3.escreve_RAM, if3.endereco_HD, if3.endereco_RAM, if3.dado_out);
  end

  function automatic logic get_conc(input bit l3);
    return l3 ? if3.concluido : if1.concluido;
  endfunction
  function automatic logic get_carr(input bit l3);
    return l3 ? if3.carregando : if1.carregando;
  endfunction
  function automatic logic get_erro(input bit l3);
    return l3 ? if3.erro : if1.erro;
  endfunction
  function automatic logic [11:0] get_ehd(input bit l3);
    return l3 ? if3.endereco_HD : if1.endereco_HD;
  endfunction
  function automatic int qsize(input bit l3);
    return l3 ? q3.size() : q1.size();
  endfunction

  task automatic drv(input bit l3, input logic st, input logic md, input logic ab, input int idx);
    if (l3) begin
      if3.Start = st; if3.Modo = md; if3.Abort = ab; if3.indice_programa = 12'(idx);
    end else begin
      if1.Start = st; if1.Modo = md; if1.Abort = ab; if1.indice_programa = 12'(idx);
    end
  endtask

  // Queue the first n writes of a transfer whose Start edge follows cycle count t0.
  task automatic push_exp(input bit l3, input bit md, input int hs, input int n,
                          input longint t0, input int lat);
    wr_t e;
    for (int k = 0; k < n; k++) begin
      e.to_hd = md;
      e.addr  = md ? 12'(hs + k) : 12'(RB + k);
      e.data  = md ? ram_word(12'(RB + k)) : hd_word(12'(hs + k));
      e.cyc   = t0 + 1 + longint'(k * (lat + 2) + lat + 1);
      if (l3) q3.push_back(e);
      else    q1.push_back(e);
    end
  endtask

  task automatic run_case(input tcase_t c);
    longint t0;
    int     n;
    int     lat;
    int     hs;
    lat = c.lat3 ? 3 : 1;
    hs  = c.idx * int'(PS) + int'(HDB);
    @(negedge clk);
    t0 = cyc;
    drv(c.lat3, 1'b1, c.modo, 1'b0, c.idx);
    if (!c.exp_err) push_exp(c.lat3, c.modo, hs, PS, t0, lat);
    @(negedge clk);
    drv(c.lat3, 1'b0, c.modo, 1'b0, c.idx);
    chk("erro_cycle1", get_erro(c.lat3), c.exp_err);
    chk("busy_cycle1", get_carr(c.lat3), !c.exp_err);
    if (c.exp_err) begin
      @(negedge clk);
      chk("erro_one_pulse", get_erro(c.lat3), 0);
      repeat (8) @(negedge clk);
      chk("busy_after_erro", get_carr(c.lat3), 0);
      chk("sb_after_erro", qsize(c.lat3), 0);
    end else begin
      n = 0;
      while (!get_conc(c.lat3) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("done_cycle", cyc - t0, c.exp_done);
      chk("busy_in_done", get_carr(c.lat3), 0);
      chk("last_hd_addr", get_ehd(c.lat3), c.exp_last);
      chk("sb_leftover", qsize(c.lat3), 0);
      @(negedge clk);
      chk("done_one_pulse", get_conc(c.lat3), 0);
    end
  endtask

  task automatic chk_zero_outputs(input bit l3, input string tag);
    if (l3) begin
      chk({tag, "_outs3"}, {if3.escreve_HD, if3.escreve_RAM, if3.carregando, if3.concluido, if3.erro}, 0);
      chk({tag, "_addr3"}, {if3.endereco_HD, if3.endereco_RAM}, 0);
      chk({tag, "_dado3"}, if3.dado_out, 0);
    end else begin
      chk({tag, "_outs1"}, {if1.escreve_HD, if1.escreve_RAM, if1.carregando, if1.concluido, if1.erro}, 0);
      chk({tag, "_addr1"}, {if1.endereco_HD, if1.endereco_RAM}, 0);
      chk({tag, "_dado1"}, if1.dado_out, 0);
    end
  endtask

  tcase_t casos[6];

  initial begin
    longint t0;
    bit     seen;
    casos[0] = '{lat3: 1'b0, modo: MODO_LOAD,  idx: 0,  exp_err: 1'b0, exp_done: 451, exp_last: 349};
    casos[1] = '{lat3: 1'b0, modo: MODO_STORE, idx: 2,  exp_err: 1'b0, exp_done: 451, exp_last: 649};
    casos[2] = '{lat3: 1'b0, modo: MODO_LOAD,  idx: 25, exp_err: 1'b1, exp_done: 0,   exp_last: 0};
    casos[3] = '{lat3: 1'b0, modo: MODO_LOAD,  idx: 24, exp_err: 1'b0, exp_done: 451, exp_last: 3949};
    casos[4] = '{lat3: 1'b1, modo: MODO_LOAD,  idx: 1,  exp_err: 1'b0, exp_done: 751, exp_last: 499};
    casos[5] = '{lat3: 1'b1, modo: MODO_STORE, idx: 0,  exp_err: 1'b0, exp_done: 751, exp_last: 349};

    rst1 = 1'b1;
    rst3 = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 1'b0, 0);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    chk_zero_outputs(1'b0, "reset");
    chk_zero_outputs(1'b1, "reset");
    rst1 = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_case(casos[i]);

    // Abort beats Start in IDLE.
    @(negedge clk);
    drv(1'b0, 1'b1, MODO_LOAD, 1'b1, 0);
    @(negedge clk);
    drv(1'b0, 1'b0, MODO_LOAD, 1'b0, 0);
    chk("abort_beats_start_busy", if1.carregando, 0);
    chk("abort_beats_start_erro", if1.erro, 0);
    repeat (6) @(negedge clk);

    // Abort in the cycle after the 10th write; a Start while busy is ignored.
    @(negedge clk);
    t0 = cyc;
    drv(1'b0, 1'b1, MODO_LOAD, 1'b0, 3);
    push_exp(1'b0, MODO_LOAD, 650, 10, t0, 1);
    @(negedge clk);
    drv(1'b0, 1'b0, MODO_LOAD, 1'b0, 3);
    while (cyc - t0 < 10) @(negedge clk);
    drv(1'b0, 1'b1, MODO_STORE, 1'b0, 7);
    @(negedge clk);
    drv(1'b0, 1'b0, MODO_LOAD, 1'b0, 3);
    while (cyc - t0 < 31) @(negedge clk);
    chk("abort_busy_before", if1.carregando, 1);
    drv(1'b0, 1'b0, MODO_LOAD, 1'b1, 3);
    @(negedge clk);
    drv(1'b0, 1'b0, MODO_LOAD, 1'b0, 3);
    chk("abort_idle_next", if1.carregando, 0);
    chk("abort_ten_writes", q1.size(), 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | if1.concluido | if1.erro;
    end
    chk("abort_no_done", seen, 0);

    // Reset asserted in the WAIT of word 2, then a clean restart from word 0.
    @(negedge clk);
    t0 = cyc;
    drv(1'b0, 1'b1, MODO_LOAD, 1'b0, 1);
    push_exp(1'b0, MODO_LOAD, 350, 2, t0, 1);
    @(negedge clk);
    drv(1'b0, 1'b0, MODO_LOAD, 1'b0, 1);
    while (cyc - t0 < 8) @(negedge clk);
    chk("pre_reset_busy", if1.carregando, 1);
    rst1 = 1'b1;
    #1;
    chk_zero_outputs(1'b0, "midreset");
    chk("midreset_sb", q1.size(), 0);
    @(negedge clk);
    rst1 = 1'b0;
    run_case('{lat3: 1'b0, modo: MODO_LOAD, idx: 1, exp_err: 1'b0, exp_done: 451, exp_last: 499});

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/controlador_transferencia.md
# controlador_transferencia

Parametrised HD↔RAM program transfer engine, next generation of the program loader. Moves exactly one program image of `PROG_SIZE` words between the HD and the RAM program window, in either direction. Supports a configurable source read latency, start/abort handshake, a done pulse and range checking. Sits between the CPU control unit (which issues `Start`) and the HD/RAM data ports.

## Interface
- `ADDR_WIDTH`, 12: width of the HD and RAM addresses and of `indice_programa`
- `DATA_WIDTH`, 32: word width
- `PROG_SIZE`, 150: words per program image
- `HD_BASE`, 200: HD address of program 0
- `RAM_BASE`, 550: RAM address of the program window
- `RAM_SIZE`, 700: RAM depth; `RAM_BASE + PROG_SIZE <= RAM_SIZE` is an elaboration-time check
- `RD_LAT`, 1: read latency of HD and RAM in cycles, ≥1
- `Clock` in 1: system clock, rising edge
- `Reset` in 1: asynchronous, active-high
- `Start` in 1: one-cycle request, sampled in IDLE only
- `Modo` in 1: 0 = load (HD→RAM), 1 = store (RAM→HD); latched on `Start`
- `Abort` in 1: cancel the transfer in progress
- `indice_programa` in ADDR_WIDTH: program index; latched on `Start`
- `dado_HD_in` in DATA_WIDTH: HD read data
- `dado_RAM_in` in DATA_WIDTH: RAM read data
- `endereco_HD` out ADDR_WIDTH: HD address
- `endereco_RAM` out ADDR_WIDTH: RAM address
- `dado_out` out DATA_WIDTH: write data to the destination
- `escreve_HD` out 1: HD write strobe
- `escreve_RAM` out 1: RAM write strobe
- `carregando` out 1: busy
- `concluido` out 1: one-cycle done pulse
- `erro` out 1: one-cycle range-error pulse

## Operation
- States: IDLE, ISSUE, WAIT, WRITE, DONE.
- **IDLE, `Start`=1 and `Abort`=0:**
  - Compute `hd_start = indice_programa*PROG_SIZE + HD_BASE` at width ADDR_WIDTH+ceil(log2(PROG_SIZE))+1 (no truncation).
  - If `hd_start + PROG_SIZE > 2^ADDR_WIDTH`: pulse `erro` and stay in IDLE.
  - Otherwise latch `Modo`, load the HD and RAM pointers (`hd_start`, `RAM_BASE`), clear the word counter and go to ISSUE.
- **ISSUE:** drive the source address (HD pointer in load mode, RAM pointer in store mode); go to WAIT.
- **WAIT:** lasts exactly `RD_LAT` cycles. The source data is captured into the data register on the edge that ends the last WAIT cycle. Then go to WRITE.
- **WRITE:** one cycle. Drive the destination address and `dado_out` = captured word, and assert `escreve_RAM` (load) or `escreve_HD` (store). On the closing edge, increment both pointers and the word counter. If the counter reaches `PROG_SIZE`, go to DONE; otherwise go to ISSUE.
- **DONE:** `concluido`=1 for one cycle, then IDLE.
- **Abort:** asserted in ISSUE, WAIT or WRITE → next state is IDLE. No write strobe occurs in the abort cycle, and neither `concluido` nor `erro` is asserted. In IDLE, `Abort` beats `Start`.
- `Start` while `carregando`=1 is ignored.
- `carregando` = 1 in ISSUE, WAIT and WRITE.
- Both write strobes are never high together, and never high outside WRITE.

## Timing
- Reset (async, any state): state IDLE; all addresses, `dado_out`, strobes, `carregando`, `concluido` and `erro` = 0. Reset mid-transfer stops all strobes immediately; no resume.
- `Start` sampled at edge 0 → ISSUE in cycle 1; `carregando` rises in cycle 1.
- Word period = `RD_LAT`+2 cycles. The k-th write (k = 0..PROG_SIZE-1) occurs in cycle 1 + k·(`RD_LAT`+2) + `RD_LAT` + 1.
- DONE in cycle 1 + PROG_SIZE·(`RD_LAT`+2). `carregando` is 0 in the DONE cycle.
- `erro` is asserted in cycle 1 for a rejected `Start`.
- Pointers never wrap: the range check guarantees the last HD address is ≤ 2^ADDR_WIDTH−1.
- Addresses hold their last value when idle.

## Structure
- Shared package `controlador_pkg`: state enum, `MODO_LOAD`/`MODO_STORE` constants, and a function computing `hd_start` width.
- Sub-module `contador_enderecos`: holds the HD/RAM pointers and the word counter, with load, increment and terminal-count outputs. The FSM, latency counter and data register stay in the top module.

## Test plan
- Load, `indice_programa`=0, `RD_LAT`=1 → 150 `escreve_RAM` pulses, RAM 550..699 written with HD 200..349 data, first write in cycle 3, `concluido` in cycle 451, `escreve_HD` never high.
- Store, `indice_programa`=2 → RAM 550..699 copied to HD 500..649, `escreve_RAM` never high.
- `indice_programa`=25 (200+3750+150 = 4100 > 4096) → `erro` pulse in cycle 1, no strobes, `carregando` stays 0; `indice_programa`=24 completes normally, last HD address 3949.
- `RD_LAT`=3, load index 1 → write period 5 cycles, data matches HD 350..499, `concluido` in cycle 751.
- `Abort` in the cycle after the 10th write → exactly 10 writes, IDLE next cycle, no `concluido`; `Start` pulsed while busy has no effect.
- `Reset` asserted mid-WAIT → all outputs 0 immediately; a subsequent `Start` restarts from word 0.
